// File: rtl/wash_supply_arbiter.sv
// wash_supply_arbiter
//
// Shares one hot-water inlet line between N dishwasher wash controllers.
// Grants the line round-robin, drives the physical supply valve from the
// granted unit's fill_valve_on, enforces a stuck-fill watchdog, and inserts
// a settle gap between grants.
//
// Handshake: req[i] is a level request that the unit raises before filling
// and holds until it is done. gnt[i] is the registered one-hot answer. The
// unit owns the inlet for every cycle gnt[i] is high. Dropping req[i]
// releases the line on the next clock edge. If req[i] is still high after
// HOLD_MAX granted cycles, the arbiter revokes the grant and marks the unit
// faulted.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   req[N]         per-unit inlet request (level)
//   fill_on[N]     per-unit fill_valve_on from each wash FSM
//   fault_clr[N]   per-unit watchdog fault clear pulse
//   gnt[N]         one-hot grant, registered
//   supply_valve   physical inlet valve drive, registered
//   busy           high while in GRANT or GUARD
//   active_id      index of the current or last granted unit
//   timeout_fault  sticky per-unit watchdog fault
module wash_supply_arbiter #(
    parameter int N         = 4,
    parameter int HOLD_MAX  = 1000,
    parameter int GUARD_CYC = 4,
    parameter int IDW       = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   fill_on,
    input  logic [N-1:0]   fault_clr,
    output logic [N-1:0]   gnt,
    output logic           supply_valve,
    output logic           busy,
    output logic [IDW-1:0] active_id,
    output logic [N-1:0]   timeout_fault
);

    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MAX - 1);
    localparam logic [HW-1:0] HOLD_SAT   = HW'(HOLD_MAX);
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [GW-1:0] GUARD_SAT  = GW'(GUARD_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // State is kept as a named enum so checkers can probe it hierarchically.
    state_t         state, state_nx;
    logic [N-1:0]   gnt_nx;
    logic           valve_nx;
    logic           busy_nx;
    logic [IDW-1:0] active_nx;
    logic [IDW-1:0] last, last_nx;
    logic [HW-1:0]  hold_cnt, hold_nx;
    logic [GW-1:0]  guard_cnt, guard_nx;
    logic [N-1:0]   fault_nx;
    logic [N-1:0]   fault_set;
    logic           leave;

    // Round-robin search: first eligible unit after the last winner.
    logic [N-1:0]   elig;
    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;

    assign elig = req & ~timeout_fault;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(last) + k) % N);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        valve_nx  = 1'b0;
        active_nx = active_id;
        last_nx   = last;
        hold_nx   = hold_cnt;
        guard_nx  = guard_cnt;
        fault_set = '0;
        leave     = 1'b0;

        case (state)
            ST_IDLE: begin
                gnt_nx = '0;
                if (found) begin
                    state_nx       = ST_GRANT;
                    gnt_nx[winner] = 1'b1;
                    active_nx      = winner;
                    last_nx        = winner;
                    hold_nx        = '0;
                end
            end
            ST_GRANT: begin
                // A release on the watchdog's final cycle is a clean release.
                if (!req[active_id]) begin
                    leave = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    leave                = 1'b1;
                    fault_set[active_id] = 1'b1;
                end

                if (leave) begin
                    gnt_nx = '0;
                    if (GUARD_CYC > 0) begin
                        state_nx = ST_GUARD;
                        guard_nx = '0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    valve_nx = fill_on[active_id];
                    if (hold_cnt != HOLD_SAT) begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
            end
            ST_GUARD: begin
                gnt_nx = '0;
                if (guard_cnt >= GUARD_LAST) begin
                    state_nx = ST_IDLE;
                end else if (guard_cnt != GUARD_SAT) begin
                    guard_nx = guard_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                gnt_nx   = '0;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
        // A new fault outranks a clear arriving on the same edge.
        fault_nx = (timeout_fault & ~fault_clr) | fault_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            gnt           <= '0;
            supply_valve  <= 1'b0;
            busy          <= 1'b0;
            active_id     <= '0;
            last          <= IDW'(N - 1);
            hold_cnt      <= '0;
            guard_cnt     <= '0;
            timeout_fault <= '0;
        end else begin
            state         <= state_nx;
            gnt           <= gnt_nx;
            supply_valve  <= valve_nx;
            busy          <= busy_nx;
            active_id     <= active_nx;
            last          <= last_nx;
            hold_cnt      <= hold_nx;
            guard_cnt     <= guard_nx;
            timeout_fault <= fault_nx;
        end
    end

endmodule

// File: tb/tb_wash_supply_arbiter.sv
// Testbench for wash_supply_arbiter.
// u_a: N=4, HOLD_MAX=8, GUARD_CYC=4. u_b: N=4, HOLD_MAX=8, GUARD_CYC=0.
module tb_wash_supply_arbiter;

    logic       clk;
    logic       rst_a, rst_b;
    logic [3:0] req_a, fill_a, clr_a;
    logic [3:0] req_b, fill_b, clr_b;
    logic [3:0] gnt_a, gnt_b, tf_a, tf_b;
    logic       valve_a, valve_b, busy_a, busy_b;
    logic [1:0] id_a, id_b;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    wash_supply_arbiter #(.N(4), .HOLD_MAX(8), .GUARD_CYC(4)) u_a (
        .clk(clk), .reset(rst_a), .req(req_a), .fill_on(fill_a), .fault_clr(clr_a),
        .gnt(gnt_a), .supply_valve(valve_a), .busy(busy_a), .active_id(id_a),
        .timeout_fault(tf_a)
    );

    wash_supply_arbiter #(.N(4), .HOLD_MAX(8), .GUARD_CYC(0)) u_b (
        .clk(clk), .reset(rst_b), .req(req_b), .fill_on(fill_b), .fault_clr(clr_b),
        .gnt(gnt_b), .supply_valve(valve_b), .busy(busy_b), .active_id(id_b),
        .timeout_fault(tf_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        tick();
    endtask

    // Scoreboard: waits (bounded) for the next grant, then compares it to
    // the front of the expected queue.
    task automatic wait_grant(input string tag, input bit use_b, output int waited);
        logic [3:0] g;
        logic [3:0] e;
        waited = 0;
        g = '0;
        do begin
            tick();
            waited++;
            g = use_b ? gnt_b : gnt_a;
        end while (g == 4'b0000 && waited < 40);
        e = 4'bxxxx;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check(tag, 32'(g), 32'(e));
    endtask

    task automatic wait_idle_a(output int n);
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int w;
        int n;
        rst_a = 1'b0; rst_b = 1'b0;
        req_a = '0; fill_a = '0; clr_a = '0;
        req_b = '0; fill_b = '0; clr_b = '0;
        #3;
        check("reset_gnt", 32'(gnt_a), 0);
        check("reset_valve", 32'(valve_a), 0);
        check("reset_busy", 32'(busy_a), 0);
        check("reset_id", 32'(id_a), 0);
        check("reset_fault", 32'(tf_a), 0);
        tick();
        rst_a = 1'b1; rst_b = 1'b1;
        tick();

        // Single request, unit 2
        req_a = 4'b0100; fill_a = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant("single_gnt", 1'b0, w);
        check("single_latency", 32'(w), 1);
        check("single_id", 32'(id_a), 2);
        check("single_busy", 32'(busy_a), 1);
        check("single_valve_lag", 32'(valve_a), 0);
        tick();
        check("single_valve_on", 32'(valve_a), 1);
        repeat (3) tick();
        check("single_still_gnt", 32'(gnt_a), 4'b0100);
        req_a = '0;
        tick();
        check("single_rel_gnt", 32'(gnt_a), 0);
        check("single_rel_valve", 32'(valve_a), 0);
        check("single_rel_busy", 32'(busy_a), 1);
        wait_idle_a(n);
        check("single_guard_len", 32'(n), 4);

        // Round robin from reset: 0,1,2,3,0
        reset_a();
        fill_a = 4'b0000;
        req_a = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        for (int i = 0; i < 5; i++) begin
            wait_grant($sformatf("rr_gnt%0d", i), 1'b0, w);
            check($sformatf("rr_wait%0d", i), 32'(w), (i == 0) ? 1 : 5);
            repeat (4) tick();
            req_a[i % 4] = 1'b0;
            tick();
            check($sformatf("rr_rel%0d", i), 32'(gnt_a), 0);
            req_a[i % 4] = 1'b1;
        end
        req_a = '0;
        wait_idle_a(n);

        // Watchdog on unit 1
        reset_a();
        req_a = 4'b0010; fill_a = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_grant("wd_gnt", 1'b0, w);
        n = 1;
        while (n < 40) begin
            tick();
            if (gnt_a != 4'b0010) break;
            n++;
        end
        check("wd_hold_len", 32'(n), 8);
        check("wd_fault", 32'(tf_a), 4'b0010);
        check("wd_valve", 32'(valve_a), 0);
        req_a = 4'b0011;
        exp_q.push_back(4'b0001);
        wait_grant("wd_skip", 1'b0, w);
        check("wd_skip_wait", 32'(w), 5);
        check("wd_fault_kept", 32'(tf_a), 4'b0010);
        req_a = 4'b0010;
        tick();
        clr_a = 4'b0010;
        tick();
        clr_a = '0;
        check("wd_clr", 32'(tf_a), 0);
        exp_q.push_back(4'b0010);
        wait_grant("wd_reenable", 1'b0, w);
        req_a = '0;
        tick();
        wait_idle_a(n);

        // Release on the watchdog's last cycle
        reset_a();
        req_a = 4'b0001; fill_a = 4'b0000;
        exp_q.push_back(4'b0001);
        wait_grant("tie_gnt", 1'b0, w);
        repeat (7) tick();
        check("tie_pre", 32'(gnt_a), 4'b0001);
        req_a = '0;
        tick();
        check("tie_rel_gnt", 32'(gnt_a), 0);
        check("tie_no_fault", 32'(tf_a), 0);
        check("tie_guard_busy", 32'(busy_a), 1);
        wait_idle_a(n);
        check("tie_guard_len", 32'(n), 4);

        // Async reset mid-grant
        req_a = 4'b0100; fill_a = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant("ar_gnt", 1'b0, w);
        tick();
        check("ar_valve_on", 32'(valve_a), 1);
        #2;
        rst_a = 1'b0;
        #1;
        check("ar_gnt_drop", 32'(gnt_a), 0);
        check("ar_valve_drop", 32'(valve_a), 0);
        check("ar_busy_drop", 32'(busy_a), 0);
        req_a = 4'b1010;
        tick();
        tick();
        check("ar_held", 32'(gnt_a), 0);
        rst_a = 1'b1;
        exp_q.push_back(4'b0010);
        wait_grant("ar_first", 1'b0, w);
        check("ar_first_id", 32'(id_a), 1);
        req_a = '0;

        // No guard gap: back-to-back via IDLE
        req_b = 4'b0011;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        wait_grant("ng_gnt0", 1'b1, w);
        tick();
        tick();
        req_b = 4'b0010;
        tick();
        check("ng_rel_gnt", 32'(gnt_b), 0);
        check("ng_rel_busy", 32'(busy_b), 0);
        wait_grant("ng_gnt1", 1'b1, w);
        check("ng_gap", 32'(w), 1);
        check("ng_id", 32'(id_b), 1);
        req_b = '0;
        tick();
        check("ng_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wash_supply_arbiter.md
Name: wash_supply_arbiter

Overview:
- Shares one hot-water inlet line between N dishwasher wash controllers.
- Each controller raises a request before its fill phase and holds it until filled.
- The arbiter grants the line round-robin and drives the single physical supply valve from the granted unit's fill_valve_on.
- It enforces a maximum hold time (stuck-fill watchdog) and a settle gap between grants. It sits between the per-unit wash FSMs and the plant valve driver.

Parameters:
N, 4, number of wash units sharing the inlet (2..8)
HOLD_MAX, 1000, max clk cycles a grant may stay high before watchdog fault (>=2)
GUARD_CYC, 4, idle cycles between grant release and next grant (0 = none)
IDW, $clog2(N), width of active_id

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  N  per-unit inlet request, level, held until unit done filling
fill_on  in  N  per-unit fill_valve_on from each wash FSM
fault_clr  in  N  per-unit fault clear pulse
gnt  out  N  one-hot grant, registered
supply_valve  out  1  physical inlet valve drive, registered
busy  out  1  high in GRANT or GUARD
active_id  out  IDW  index of current/last granted unit
timeout_fault  out  N  sticky per-unit watchdog fault

Behaviour:
- Reset (reset=0, async): state=IDLE, gnt=0, supply_valve=0, busy=0, active_id=0, timeout_fault=0, hold_cnt=0, guard_cnt=0, rr pointer last=N-1 (unit 0 has first priority).
- Eligible set: elig = req & ~timeout_fault.
- IDLE: if elig!=0, pick the first set bit scanning last+1, last+2, ... modulo N.
  - Next edge: gnt=onehot(winner), active_id=winner, last=winner, hold_cnt=0, state=GRANT.
  - Latency: req sampled high at edge k produces gnt at edge k+1.
- GRANT:
  - supply_valve registered = fill_on[active_id]; one-cycle latency; forced 0 outside GRANT.
  - hold_cnt increments each cycle.
  - Release: req[active_id]=0 at an edge -> gnt=0, supply_valve=0 at that edge.
    - If GUARD_CYC>0: state=GUARD, guard_cnt=0.
    - If GUARD_CYC=0: state=IDLE.
  - Watchdog: req still 1 when gnt has been high HOLD_MAX cycles (hold_cnt==HOLD_MAX-1) -> timeout_fault[active_id]=1, gnt=0, supply_valve=0, go to GUARD/IDLE as for release.
  - Release and timeout in the same cycle: release wins, no fault.
- GUARD: gnt=0, supply_valve=0. guard_cnt counts to GUARD_CYC-1, then IDLE. Requests during GUARD are ignored until IDLE.
- busy=1 in GRANT and GUARD, 0 in IDLE (registered with state).
- Faulted unit: excluded from arbitration until fault_clr[i]=1. fault_clr clears on the next edge. Simultaneous set and clr of the same bit: set wins. fault_clr on a non-faulted bit has no effect.
- fault_clr for the active unit during GRANT does not affect the ongoing grant.
- Fairness: a unit that just released has lowest priority next round. Worst-case wait for a continuously requesting unit is (N-1)*(HOLD_MAX+GUARD_CYC+1) cycles.
- Width rules:
  - hold_cnt width $clog2(HOLD_MAX+1).
  - guard_cnt width $clog2(GUARD_CYC+1), minimum 1.
  - Counters saturate and never wrap.
- gnt is always one-hot or zero, never multi-hot.
- reset asserted mid-GRANT: gnt and supply_valve drop immediately (async). After release, arbitration restarts from unit 0.

Test Plan:
- Single request: req=4'b0100 held 10 cycles then dropped, fill_on[2]=1 -> gnt=4'b0100 one cycle after req; supply_valve=1 one cycle after gnt; both 0 on release edge; busy high for 10+GUARD_CYC cycles.
- Round-robin: req=4'b1111 held, each unit drops req 5 cycles after its grant, GUARD_CYC=4 -> grant order 0,1,2,3,0; 4-cycle gaps with gnt=0 between grants.
- Watchdog: HOLD_MAX=8, req[1] held forever -> gnt[1] high exactly 8 cycles; timeout_fault=4'b0010; unit 1 skipped afterwards; fault_clr[1] pulse re-enables it.
- Release vs timeout tie: req[0] drops on the same edge hold_cnt reaches HOLD_MAX-1 -> no fault, normal GUARD.
- GUARD_CYC=0: back-to-back requests 0 and 1 -> gnt[1] asserts one cycle after gnt[0] drops, via IDLE.
- Async reset mid-GRANT: reset low asynchronously -> gnt=0, supply_valve=0, busy=0 without a clock edge. After release with req=4'b1010, unit 1 is granted first.
